// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: operation control codes and FSM states.
package alu_pkg;

    // Decoded ALU operation; the numeric values are visible on the alu_ctrl trace port.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_ctrl_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Shift operations go through the one-bit-per-cycle shifter.
    function automatic logic is_shift(alu_ctrl_e c);
        return (c == ALU_SLL) || (c == ALU_SRL) || (c == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of main-decoder class plus funct fields into an ALU control code.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       op_5,
    input  logic       funct7_5,
    output logic [3:0] alu_ctrl
);

    alu_ctrl_e ctrl;

    // Map instruction fields to an operation; reserved class 11 falls back to ADD.
    always_comb begin
        // NOTE: default first so every path assigns ctrl and no latch is inferred.
        ctrl = ALU_ADD;
        case (ALUOp)
            2'b01: ctrl = ALU_SUB;
            2'b10: begin
                case (funct3)
                    3'b000:  ctrl = (op_5 & funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  ctrl = ALU_SLL;
                    3'b010:  ctrl = ALU_SLT;
                    3'b011:  ctrl = ALU_SLTU;
                    3'b100:  ctrl = ALU_XOR;
                    3'b101:  ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  ctrl = ALU_OR;
                    default: ctrl = ALU_AND;
                endcase
            end
            default: ctrl = ALU_ADD;
        endcase
    end

    assign alu_ctrl = ctrl;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic, shifts done one bit per cycle
// through a single shifter, valid/ready handshake on both sides.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUOp,
    input  logic [2:0]       funct3,
    input  logic             op_5,
    input  logic             funct7_5,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [3:0]       alu_ctrl
);

    state_e           state;
    alu_ctrl_e        ctrl_q;
    logic [SHW-1:0]   cnt;
    logic [3:0]       dec_ctrl;
    alu_ctrl_e        dec_op;
    logic [SHW-1:0]   shamt;
    logic             accept;

    alu_ctrl_dec u_dec (
        .ALUOp    (ALUOp),
        .funct3   (funct3),
        .op_5     (op_5),
        .funct7_5 (funct7_5),
        .alu_ctrl (dec_ctrl)
    );

    assign dec_op   = alu_ctrl_e'(dec_ctrl);
    assign shamt    = b[SHW-1:0];
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign zero     = (result == '0);
    assign alu_ctrl = ctrl_q;

    // Single-cycle operations; shifts return the operand unchanged (shamt 0 result).
    function automatic logic [WIDTH-1:0] alu_comb(alu_ctrl_e c, logic [WIDTH-1:0] x,
                                                  logic [WIDTH-1:0] y);
        case (c)
            ALU_ADD:  return x + y;
            ALU_SUB:  return x - y;
            ALU_AND:  return x & y;
            ALU_OR:   return x | y;
            ALU_XOR:  return x ^ y;
            ALU_SLT:  return {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            ALU_SLTU: return {{(WIDTH-1){1'b0}}, (x < y)};
            default:  return x;
        endcase
    endfunction

    // One-position shift of the working register.
    function automatic logic [WIDTH-1:0] shift_one(alu_ctrl_e c, logic [WIDTH-1:0] x);
        case (c)
            ALU_SLL: return {x[WIDTH-2:0], 1'b0};
            ALU_SRA: return {x[WIDTH-1], x[WIDTH-1:1]};
            default: return {1'b0, x[WIDTH-1:1]};
        endcase
    endfunction

    // Sequencer: capture on accept, iterate shifts, hold result until consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: state updates use <= so every register samples pre-edge values.
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            ctrl_q    <= ALU_ADD;
            cnt       <= '0;
        end else if (accept) begin
            ctrl_q <= dec_op;
            result <= alu_comb(dec_op, a, b);
            if (is_shift(dec_op) && (shamt != '0)) begin
                state     <= SHIFT;
                out_valid <= 1'b0;
                cnt       <= shamt;
            end else begin
                state     <= DONE;
                out_valid <= 1'b1;
            end
        end else begin
            case (state)
                SHIFT: begin
                    result <= shift_one(ctrl_q, result);
                    cnt    <= cnt - 1'b1;
                    if (cnt == SHW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: vector table at WIDTH=32 plus handshake, reset and
// WIDTH=8 sequences.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        reset;

    logic        in_valid, in_ready, op_5, funct7_5, out_valid, out_ready, zero;
    logic [1:0]  ALUOp;
    logic [2:0]  funct3;
    logic [31:0] a, b, result;
    logic [3:0]  alu_ctrl;

    logic        in_valid8, in_ready8, op_58, funct7_58, out_valid8, out_ready8, zero8;
    logic [1:0]  ALUOp8;
    logic [2:0]  funct38;
    logic [7:0]  a8, b8, result8;
    logic [3:0]  alu_ctrl8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .funct3(funct3), .op_5(op_5), .funct7_5(funct7_5),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .alu_ctrl(alu_ctrl)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .ALUOp(ALUOp8), .funct3(funct38), .op_5(op_58), .funct7_5(funct7_58),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .zero(zero8), .alu_ctrl(alu_ctrl8)
    );

    typedef struct {
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic        op5;
        logic        f75;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  ctrl;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic o5,
                         input logic f75, input logic [31:0] x, input logic [31:0] y);
        in_valid = 1'b1;
        ALUOp = op; funct3 = f3; op_5 = o5; funct7_5 = f75; a = x; b = y;
    endtask

    // Issue one request from IDLE, wait for the result, consume it.
    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        drive(v.aluop, v.f3, v.op5, v.f75, v.a, v.b);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 80) begin
            tick();
            cyc++;
        end
        check($sformatf("v%0d latency", idx), 64'(cyc), 64'(v.lat));
        check($sformatf("v%0d result", idx), 64'(result), 64'(v.res));
        check($sformatf("v%0d zero", idx), 64'(zero), 64'(v.res == 32'd0));
        check($sformatf("v%0d alu_ctrl", idx), 64'(alu_ctrl), 64'(v.ctrl));
        tick();
        check($sformatf("v%0d back to idle", idx), 64'(out_valid), 64'd0);
    endtask

    task automatic run8(input string name, input logic [1:0] op, input logic [2:0] f3,
                        input logic f75, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] exp, input int lat);
        int cyc;
        in_valid8 = 1'b1; ALUOp8 = op; funct38 = f3; op_58 = 1'b0; funct7_58 = f75;
        a8 = x; b8 = y; out_ready8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        cyc = 1;
        while (!out_valid8 && cyc < 40) begin
            tick();
            cyc++;
        end
        check({name, " latency"}, 64'(cyc), 64'(lat));
        check({name, " result"}, 64'(result8), 64'(exp));
        check({name, " zero"}, 64'(zero8), 64'(exp == 8'd0));
        tick();
    endtask

    initial begin
        int cyc;
        int seen;

        vecs[0]  = '{2'b10, 3'b000, 1'b1, 1'b1, 32'd5,         32'd7,         32'hFFFFFFFE, 4'd1, 1};
        vecs[1]  = '{2'b00, 3'b000, 1'b0, 1'b0, 32'h7FFFFFFF,  32'd1,         32'h80000000, 4'd0, 1};
        vecs[2]  = '{2'b01, 3'b000, 1'b0, 1'b0, 32'd3,         32'd3,         32'h00000000, 4'd1, 1};
        vecs[3]  = '{2'b11, 3'b111, 1'b1, 1'b1, 32'd10,        32'd20,        32'd30,       4'd0, 1};
        vecs[4]  = '{2'b10, 3'b000, 1'b0, 1'b1, 32'd5,         32'd7,         32'd12,       4'd0, 1};
        vecs[5]  = '{2'b10, 3'b111, 1'b1, 1'b0, 32'hF0F0F0F0,  32'h0FF00FF0,  32'h00F000F0, 4'd2, 1};
        vecs[6]  = '{2'b10, 3'b110, 1'b1, 1'b0, 32'hF0F00000,  32'h00000F0F,  32'hF0F00F0F, 4'd3, 1};
        vecs[7]  = '{2'b10, 3'b100, 1'b1, 1'b0, 32'hFFFF0000,  32'hFF00FF00,  32'h00FFFF00, 4'd4, 1};
        vecs[8]  = '{2'b10, 3'b011, 1'b1, 1'b0, 32'd1,         32'hFFFFFFFF,  32'd1,        4'd6, 1};
        vecs[9]  = '{2'b10, 3'b010, 1'b1, 1'b0, 32'd1,         32'hFFFFFFFF,  32'd0,        4'd5, 1};
        vecs[10] = '{2'b10, 3'b010, 1'b1, 1'b0, 32'hFFFFFFFF,  32'd1,         32'd1,        4'd5, 1};
        vecs[11] = '{2'b10, 3'b101, 1'b1, 1'b1, 32'h80000000,  32'd4,         32'hF8000000, 4'd9, 5};
        vecs[12] = '{2'b10, 3'b101, 1'b1, 1'b0, 32'h80000000,  32'd4,         32'h08000000, 4'd8, 5};
        vecs[13] = '{2'b10, 3'b001, 1'b1, 1'b0, 32'd1,         32'd3,         32'd8,        4'd7, 4};
        vecs[14] = '{2'b10, 3'b001, 1'b1, 1'b0, 32'hDEADBEEF,  32'h00000020,  32'hDEADBEEF, 4'd7, 1};
        vecs[15] = '{2'b10, 3'b101, 1'b0, 1'b1, 32'h80000000,  32'd31,        32'hFFFFFFFF, 4'd9, 32};
        vecs[16] = '{2'b10, 3'b001, 1'b1, 1'b0, 32'd3,         32'd31,        32'h80000000, 4'd7, 32};
        vecs[17] = '{2'b10, 3'b101, 1'b1, 1'b0, 32'hFFFFFFFF,  32'd1,         32'h7FFFFFFF, 4'd8, 2};

        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; ALUOp = '0; funct3 = '0; op_5 = 1'b0;
        funct7_5 = 1'b0; a = '0; b = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; ALUOp8 = '0; funct38 = '0; op_58 = 1'b0;
        funct7_58 = 1'b0; a8 = '0; b8 = '0;
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset zero", 64'(zero), 64'd1);
        check("reset alu_ctrl", 64'(alu_ctrl), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        tick();
        tick();
        reset = 1'b0;

        // Table: first vector goes in on the first edge after release.
        for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

        // SRA with in_ready low for 4 cycles while the request inputs keep changing.
        drive(2'b10, 3'b101, 1'b1, 1'b1, 32'h80000000, 32'd4);
        tick();
        drive(2'b00, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("sra in_ready c%0d", k), 64'(in_ready), 64'd0);
            check($sformatf("sra out_valid c%0d", k), 64'(out_valid), 64'd0);
            a = 32'(k * 17);
            tick();
        end
        in_valid = 1'b0;
        check("sra out_valid c5", 64'(out_valid), 64'd1);
        check("sra result", 64'(result), 64'hF8000000);
        check("sra alu_ctrl", 64'(alu_ctrl), 64'd9);
        tick();

        // Backpressure in DONE, then back-to-back acceptance.
        out_ready = 1'b0;
        drive(2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2);
        tick();
        drive(2'b01, 3'b000, 1'b0, 1'b0, 32'd9, 32'd4);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("hold out_valid %0d", k), 64'(out_valid), 64'd1);
            check($sformatf("hold result %0d", k), 64'(result), 64'd3);
            check($sformatf("hold zero %0d", k), 64'(zero), 64'd0);
            check($sformatf("hold alu_ctrl %0d", k), 64'(alu_ctrl), 64'd0);
            check($sformatf("hold in_ready %0d", k), 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("release in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("b2b out_valid", 64'(out_valid), 64'd1);
        check("b2b result", 64'(result), 64'd5);
        check("b2b alu_ctrl", 64'(alu_ctrl), 64'd1);
        tick();
        check("b2b idle", 64'(out_valid), 64'd0);

        // Reset in cycle 10 of a 31-position SLL discards the operation.
        drive(2'b10, 3'b001, 1'b1, 1'b0, 32'd1, 32'd31);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        #2;
        reset = 1'b1;
        #1;
        check("mid-shift reset out_valid", 64'(out_valid), 64'd0);
        check("mid-shift reset result", 64'(result), 64'd0);
        check("mid-shift reset zero", 64'(zero), 64'd1);
        check("mid-shift reset alu_ctrl", 64'(alu_ctrl), 64'd0);
        check("mid-shift reset in_ready", 64'(in_ready), 64'd1);
        tick();
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (out_valid) seen++;
        end
        check("no stale result", 64'(seen), 64'd0);

        // Reset while in DONE, then accept on the first edge after release.
        drive(2'b00, 3'b000, 1'b0, 1'b0, 32'd4, 32'd4);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("done reset out_valid", 64'(out_valid), 64'd0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        drive(2'b01, 3'b000, 1'b0, 1'b0, 32'd10, 32'd3);
        tick();
        in_valid = 1'b0;
        check("first accept out_valid", 64'(out_valid), 64'd1);
        check("first accept result", 64'(result), 64'd7);
        tick();

        // WIDTH=8 instance: wrap-around, signed compare, full-width arithmetic shift.
        run8("w8 add wrap", 2'b00, 3'b000, 1'b0, 8'hFF, 8'h01, 8'h00, 1);
        run8("w8 slt", 2'b10, 3'b010, 1'b0, 8'h80, 8'h01, 8'h01, 1);
        run8("w8 sra7", 2'b10, 3'b101, 1'b1, 8'h80, 8'h07, 8'hFF, 8);

        cyc = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width (derived, not overridden).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 ALUOp  input  2  main-decoder class: 00 add, 01 sub, 10 funct3-decoded, 11 reserved.
REQ-008 funct3  input  3  instruction funct3.
REQ-009 op_5  input  1  opcode bit 5 (R-type vs I-type).
REQ-010 funct7_5  input  1  instruction funct7 bit 5.
REQ-011 a, b  input  WIDTH each  operands.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer takes result this cycle.
REQ-014 result  output  WIDTH  operation result.
REQ-015 zero  output  1  high when result == 0.
REQ-016 alu_ctrl  output  4  decoded control of the operation held in result (debug/trace).

Function
REQ-017 Decode SHALL map ALUOp 00 and 11 to ADD, 01 to SUB; for ALUOp 10, funct3 000 to SUB if op_5&funct7_5 else ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRA if funct7_5 else SRL, 110 OR, 111 AND.
REQ-018 alu_ctrl encoding SHALL be ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9; codes 10-15 unused.
REQ-019 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-020 in_ready SHALL be 1 in IDLE, and in DONE when out_ready=1; 0 in SHIFT.
REQ-021 A request SHALL be accepted on a cycle where in_valid&in_ready; operands and decode captured on that edge.
REQ-022 Non-shift ops SHALL enter DONE with result registered on the accepting edge (latency 1).
REQ-023 Shift ops SHALL use shamt = b[SHW-1:0]; shamt 0 enters DONE directly (latency 1), else enter SHIFT.
REQ-024 In SHIFT, the working register SHALL shift one position per cycle (SRA replicating MSB, SRL/SLL filling 0) and a down-counter loaded with shamt SHALL decrement; transition to DONE when counter reaches 1 after its shift, giving latency shamt+1.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH; SLT signed, SLTU unsigned, result 0/1 zero-extended.
REQ-026 out_valid SHALL be 1 exactly in DONE; result, zero and alu_ctrl SHALL be stable while out_valid&~out_ready.
REQ-027 DONE with out_ready=1 and in_valid=0 SHALL return to IDLE; with in_valid=1 SHALL accept back-to-back (no bubble).
REQ-028 in_valid or operand changes during SHIFT SHALL have no effect.

Reset
REQ-029 reset SHALL asynchronously force state IDLE, out_valid 0, result 0, zero 1, alu_ctrl 0, shift counter 0.
REQ-030 reset asserted mid-SHIFT or mid-DONE SHALL discard the operation; no result is ever presented for it.
REQ-031 First acceptance after reset deassertion SHALL be possible on the first rising edge with reset low.

Structure
REQ-032 Shared package alu_pkg SHALL hold the alu_ctrl enum (REQ-018) and the FSM state enum.
REQ-033 Decode SHALL be a separate combinational sub-module alu_ctrl_dec (inputs ALUOp, funct3, op_5, funct7_5; output 4-bit control).
REQ-034 Only one shifter (single-position) SHALL exist; no barrel shifter.

Verification
REQ-035 WIDTH=32, ALUOp=10, funct3=000, op_5=1, funct7_5=1, a=5, b=7 -> one cycle later out_valid=1, result=32'hFFFFFFFE, zero=0, alu_ctrl=1.
REQ-036 ALUOp=10, funct3=101, funct7_5=1, a=32'h80000000, b=4 -> in_ready low 4 cycles, out_valid on 5th cycle, result=32'hF8000000, alu_ctrl=9.
REQ-037 ALUOp=10, funct3=011, a=1, b=32'hFFFFFFFF -> result=1; funct3=010 same operands -> result=0, zero=1.
REQ-038 out_ready held 0 for 3 cycles in DONE -> result/zero/alu_ctrl unchanged, in_ready=0; then out_ready=1 with in_valid=1 -> next request accepted same edge, no bubble.
REQ-039 SLL b=31 issued, reset pulsed in cycle 10 -> out_valid=0, result=0, state IDLE; no stale result after release.
REQ-040 WIDTH=8, ALUOp=00, a=8'hFF, b=8'h01 -> result=8'h00, zero=1 (wrap-around).
